mem_arbiter: RTL and testbench

Single-port memory arbiter and access sequencer. It shares one unified instruction/data memory between two requesters: the fetch stage (instruction reads) and the memory stage (data loads and stores). Each access runs through a multi-cycle issue/wait/respond sequence. Per-requester stall signals hold the pipeline stages until their access completes.

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch and memory stages,
// running each access through issue, latency wait and a one-cycle completion pulse.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  output logic                     if_valid,
  input  logic                     dm_req,
  input  logic                     dm_we,
  input  logic [ADDRESS_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0]    dm_wdata,
  output logic [DATA_WIDTH-1:0]    dm_rdata,
  output logic                     dm_valid,
  output logic                     stall_f,
  output logic                     stall_m,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  logic [1:0]               state_q,      state_d;
  logic                     owner_q,      owner_d;
  logic                     last_owner_q, last_owner_d;
  logic [ADDRESS_WIDTH-1:0] addr_q,       addr_d;
  logic                     we_q,         we_d;
  logic [DATA_WIDTH-1:0]    wdata_q,      wdata_d;
  logic [3:0]               cnt_q,        cnt_d;
  logic [DATA_WIDTH-1:0]    if_rdata_q,   if_rdata_d;
  logic [DATA_WIDTH-1:0]    dm_rdata_q,   dm_rdata_d;
  logic                     if_valid_q,   if_valid_d;
  logic                     dm_valid_q,   dm_valid_d;
  logic                     mem_en_q,     mem_en_d;
  logic                     mem_we_q,     mem_we_d;

  logic grant_s;
  logic grant_data_s;
  logic to_done_s;

  // Round-robin arbitration: on a tie the requester not served last wins.
  always_comb begin
    if (if_req && dm_req) begin
      grant_s      = 1'b1;
      grant_data_s = (last_owner_q == OWN_FETCH);
    end else if (dm_req) begin
      grant_s      = 1'b1;
      grant_data_s = 1'b1;
    end else if (if_req) begin
      grant_s      = 1'b1;
      grant_data_s = 1'b0;
    end else begin
      grant_s      = 1'b0;
      grant_data_s = 1'b0;
    end
  end

  // Access sequencer next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    to_done_s    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          owner_d      = grant_data_s;
          last_owner_d = grant_data_s;
          addr_d       = grant_data_s ? dm_addr : if_addr;
          we_d         = grant_data_s & dm_we;
          wdata_d      = grant_data_s ? dm_wdata : wdata_q;
          mem_en_d     = 1'b1;
          mem_we_d     = grant_data_s & dm_we;
          state_d      = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          to_done_s = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          // The read word is on mem_rdata in exactly this cycle.
          if (owner_q == OWN_DATA) begin
            dm_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          to_done_s = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (to_done_s) begin
      if_valid_d = (owner_q == OWN_FETCH);
      dm_valid_d = (owner_q == OWN_DATA);
    end else begin
      if_valid_d = 1'b0;
      dm_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_FETCH;
      last_owner_q <= OWN_FETCH;
      addr_q       <= {ADDRESS_WIDTH{1'b0}};
      we_q         <= 1'b0;
      wdata_q      <= {DATA_WIDTH{1'b0}};
      cnt_q        <= 4'd0;
      if_rdata_q   <= {DATA_WIDTH{1'b0}};
      dm_rdata_q   <= {DATA_WIDTH{1'b0}};
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_valid_q   <= if_valid_d;
      dm_valid_q   <= dm_valid_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign stall_f = if_req & ~if_valid_q;
  assign stall_m = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural memory, scoreboard of expected
// completions popped by a monitor, and cycle-exact timing checks per access.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          stall_f;
  logic          stall_m;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Behavioural memory: unwritten words read as a pattern, reads return LAT cycles after mem_en.
  logic [DW-1:0] mem_q   [0:255];
  bit            wr_q    [0:255];
  logic [DW-1:0] pipe_q  [0:LAT-1];

  function automatic logic [DW-1:0] init_word(input logic [7:0] idx);
    if (idx == 8'd1) return 32'h00500093;
    return {8'hA5, 16'h0000, idx};
  endfunction

  function automatic logic [DW-1:0] mem_peek(input logic [AW-1:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    return wr_q[idx] ? mem_q[idx] : init_word(idx);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_q[mem_addr[9:2]] <= mem_wdata;
      wr_q[mem_addr[9:2]]  <= 1'b1;
    end
    pipe_q[0] <= (mem_en && !mem_we) ? mem_peek(mem_addr) : 32'h0;
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign mem_rdata = pipe_q[LAT-1];

  typedef struct { bit is_data; logic [DW-1:0] rdata; } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  int tests_run = 0;
  int fails     = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (if_valid || dm_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", {30'h0, if_valid, dm_valid}, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("grant_owner", {30'h0, if_valid, dm_valid}, {30'h0, !mon_e.is_data, mon_e.is_data});
        check("rdata", mon_e.is_data ? dm_rdata : if_rdata, mon_e.rdata);
      end
    end
  end

  // Follows one access for exp_n cycles, checking strobe, stall and valid timing.
  task automatic run_access(input bit is_data, input int exp_n, input int issue_n,
                            input logic [AW-1:0] exp_addr, input bit exp_we,
                            input logic [DW-1:0] exp_wdata);
    logic v, s;
    for (int n = 1; n <= exp_n; n++) begin
      @(negedge clk);
      v = is_data ? dm_valid : if_valid;
      s = is_data ? stall_m : stall_f;
      if (n == issue_n) begin
        check("mem_en_issue", {31'h0, mem_en}, 32'd1);
        check("mem_we_issue", {31'h0, mem_we}, {31'h0, exp_we});
        check("mem_addr_issue", mem_addr, exp_addr);
        if (exp_we) check("mem_wdata_issue", mem_wdata, exp_wdata);
      end else begin
        check("mem_en_off", {31'h0, mem_en}, 32'd0);
      end
      if (n == exp_n) begin
        check("valid_on_time", {31'h0, v}, 32'd1);
        check("stall_low_at_valid", {31'h0, s}, 32'd0);
      end else begin
        check("valid_early", {31'h0, v}, 32'd0);
        check("stall_high", {31'h0, s}, 32'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h08; dm_addr = 32'h100; dm_wdata = 32'h0;

    repeat (2) begin
      @(negedge clk);
      check("rst_mem_en", {31'h0, mem_en}, 32'd0);
      check("rst_mem_we", {31'h0, mem_we}, 32'd0);
      check("rst_valids", {30'h0, if_valid, dm_valid}, 32'd0);
      check("rst_if_rdata", if_rdata, 32'h0);
      check("rst_dm_rdata", dm_rdata, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
    end
    rst = 1'b0;

    // Both held: data first, then fetch, then data again.
    sb_q.push_back('{1'b1, 32'hA5000040});
    sb_q.push_back('{1'b0, 32'hA5000002});
    sb_q.push_back('{1'b1, 32'hA5000040});
    run_access(1'b1, 2 + LAT, 1, 32'h100, 1'b0, 32'h0);
    check("loser_stall_f", {31'h0, stall_f}, 32'd1);
    run_access(1'b0, 3 + LAT, 2, 32'h08, 1'b0, 32'h0);
    check("loser_stall_m", {31'h0, stall_m}, 32'd1);
    run_access(1'b1, 3 + LAT, 2, 32'h100, 1'b0, 32'h0);
    if_req = 1'b0; dm_req = 1'b0;

    // Single fetch read.
    @(negedge clk);
    if_addr = 32'h04; if_req = 1'b1;
    sb_q.push_back('{1'b0, 32'h00500093});
    #1;
    check("stall_f_at_t", {31'h0, stall_f}, 32'd1);
    run_access(1'b0, 2 + LAT, 1, 32'h04, 1'b0, 32'h0);
    if_req = 1'b0;

    // Store leaves dm_rdata at the previous load value.
    @(negedge clk);
    dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEADBEEF; dm_req = 1'b1;
    sb_q.push_back('{1'b1, 32'hA5000040});
    run_access(1'b1, 2, 1, 32'h80, 1'b1, 32'hDEADBEEF);
    dm_req = 1'b0; dm_we = 1'b0;
    check("mem_written", mem_q[32], 32'hDEADBEEF);

    @(negedge clk);
    dm_addr = 32'h80; dm_req = 1'b1;
    sb_q.push_back('{1'b1, 32'hDEADBEEF});
    run_access(1'b1, 2 + LAT, 1, 32'h80, 1'b0, 32'h0);
    dm_req = 1'b0;

    // Fetch aborted by reset during WAIT: no completion, rdata cleared.
    @(negedge clk);
    if_addr = 32'h0C; if_req = 1'b1;
    repeat ((LAT >= 2) ? 3 : 2) @(negedge clk);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    check("abort_if_valid", {31'h0, if_valid}, 32'd0);
    check("abort_if_rdata", if_rdata, 32'h0);
    check("abort_dm_rdata", dm_rdata, 32'h0);
    check("abort_mem_en", {31'h0, mem_en}, 32'd0);
    rst = 1'b0;
    repeat (LAT + 3) begin
      @(negedge clk);
      check("abort_no_valid", {30'h0, if_valid, dm_valid}, 32'd0);
    end

    // A later fetch completes normally from IDLE.
    if_addr = 32'h0C; if_req = 1'b1;
    sb_q.push_back('{1'b0, 32'hA5000003});
    run_access(1'b0, 2 + LAT, 1, 32'h0C, 1'b0, 32'h0);
    if_req = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
